sync_mod_counter: RTL and testbench

SYNC_MOD_COUNTER -- requirements
Module: sync_mod_counter

---
 rtl/sync_mod_counter_if.sv | 26 ++
 rtl/sync_mod_counter.sv | 87 ++++++++
 tb/tb_sync_mod_counter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sync_mod_counter_if.sv
// Control/status bundle for sync_mod_counter: requests driven by the master,
// count and flags returned by the counter on the slave side.
interface sync_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             sat;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, up, sat, clr, load, din,
        input  q, tc, wrap, ovf
    );

    modport slave (
        input  en, up, sat, clr, load, din,
        output q, tc, wrap, ovf
    );
endinterface

// File: rtl/sync_mod_counter.sv
// Up/down modulo-(MAX+1) counter with wrap or saturate boundary behaviour,
// clamped parallel load, one-cycle wrap pulse and sticky overflow flag.
module sync_mod_counter #(
    parameter int          WIDTH = 4,
    parameter int unsigned MAX   = 15
) (
    input  logic              clk,
    input  logic              rst,
    sync_mod_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_Q = MAX[WIDTH-1:0];

    typedef struct packed {
        logic             wrap_ev;
        logic             ovf_ev;
        logic [WIDTH-1:0] nxt;
    } step_t;

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic             ovf_r;
    step_t            st;

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
        return (val > MAX_Q) ? MAX_Q : val;
    endfunction

    // Out-of-range states (only possible when MAX < 2^WIDTH-1) are recovered
    // to the boundary the current mode would settle on, flagged as overflow.
    function automatic step_t step_count(input logic [WIDTH-1:0] cur,
                                         input logic             dir_up,
                                         input logic             sat_mode);
        step_t s;
        s.wrap_ev = 1'b0;
        s.ovf_ev  = 1'b0;
        s.nxt     = cur;
        if (cur > MAX_Q) begin
            s.ovf_ev = 1'b1;
            s.nxt    = sat_mode ? MAX_Q : '0;
        end else if (dir_up && cur == MAX_Q) begin
            s.ovf_ev = 1'b1;
            if (!sat_mode) begin
                s.nxt     = '0;
                s.wrap_ev = 1'b1;
            end
        end else if (!dir_up && cur == '0) begin
            s.ovf_ev = 1'b1;
            if (!sat_mode) begin
                s.nxt     = MAX_Q;
                s.wrap_ev = 1'b1;
            end
        end else if (dir_up) begin
            s.nxt = cur + WIDTH'(1);
        end else begin
            s.nxt = cur - WIDTH'(1);
        end
        return s;
    endfunction

    always_comb begin
        st = step_count(q_r, bus.up, bus.sat);
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (bus.load) begin
            q_r    <= clamp_load(bus.din);
            wrap_r <= 1'b0;
        end else if (bus.en) begin
            q_r    <= st.nxt;
            wrap_r <= st.wrap_ev;
            ovf_r  <= ovf_r | st.ovf_ev;
        end else begin
            wrap_r <= 1'b0;
        end
    end

    assign bus.q    = q_r;
    assign bus.wrap = wrap_r;
    assign bus.ovf  = ovf_r;
    assign bus.tc   = (bus.up && q_r == MAX_Q) || (!bus.up && q_r == '0);

endmodule

// File: tb/tb_sync_mod_counter.sv
// Directed bench for sync_mod_counter in three configurations:
// WIDTH=4/MAX=9, WIDTH=8/MAX=255 and WIDTH=2/MAX=1.
module tb_sync_mod_counter;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sync_mod_counter_if #(.WIDTH(4)) a_if ();
    sync_mod_counter_if #(.WIDTH(8)) b_if ();
    sync_mod_counter_if #(.WIDTH(2)) c_if ();

    sync_mod_counter #(.WIDTH(4), .MAX(9))   dut_a (.clk(clk), .rst(rst_a), .bus(a_if.slave));
    sync_mod_counter #(.WIDTH(8), .MAX(255)) dut_b (.clk(clk), .rst(rst_b), .bus(b_if.slave));
    sync_mod_counter #(.WIDTH(2), .MAX(1))   dut_c (.clk(clk), .rst(rst_c), .bus(c_if.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int exp_up_q [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_dn_q [6]  = '{3, 2, 1, 0, 0, 0};
    int exp_dn_ov[6]  = '{0, 0, 0, 0, 1, 1};
    int exp_c_q  [4]  = '{1, 0, 1, 0};
    int exp_c_w  [4]  = '{0, 1, 0, 1};

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        a_if.en = 0; a_if.up = 0; a_if.sat = 0; a_if.clr = 0; a_if.load = 0; a_if.din = '0;
        b_if.en = 0; b_if.up = 0; b_if.sat = 0; b_if.clr = 0; b_if.load = 0; b_if.din = '0;
        c_if.en = 0; c_if.up = 0; c_if.sat = 0; c_if.clr = 0; c_if.load = 0; c_if.din = '0;
        tick();
        check("a_rst_q", 32'(a_if.q), 0);
        check("a_rst_wrap", 32'(a_if.wrap), 0);
        check("a_rst_ovf", 32'(a_if.ovf), 0);
        check("a_rst_tc_down", 32'(a_if.tc), 1);

        // Continuous wrap-mode up count through the terminal value
        rst_a = 0; a_if.en = 1; a_if.up = 1; a_if.sat = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("a_up_q[%0d]", i), 32'(a_if.q), 32'(exp_up_q[i]));
            check($sformatf("a_up_wrap[%0d]", i), 32'(a_if.wrap), (i == 9) ? 32'd1 : 32'd0);
            check($sformatf("a_up_ovf[%0d]", i), 32'(a_if.ovf), (i >= 9) ? 32'd1 : 32'd0);
            if (i == 8) check("a_tc_at_max", 32'(a_if.tc), 1);
        end

        a_if.en = 0; a_if.clr = 1;
        tick();
        check("a_clr_q", 32'(a_if.q), 0);
        check("a_clr_ovf", 32'(a_if.ovf), 0);
        a_if.clr = 0;

        // Saturating down count from a loaded value
        a_if.load = 1; a_if.din = 4'd4;
        tick();
        check("a_load4_q", 32'(a_if.q), 4);
        check("a_load4_wrap", 32'(a_if.wrap), 0);
        a_if.load = 0; a_if.en = 1; a_if.up = 0; a_if.sat = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("a_dn_q[%0d]", i), 32'(a_if.q), 32'(exp_dn_q[i]));
            check($sformatf("a_dn_wrap[%0d]", i), 32'(a_if.wrap), 0);
            check($sformatf("a_dn_ovf[%0d]", i), 32'(a_if.ovf), 32'(exp_dn_ov[i]));
        end

        a_if.en = 0; a_if.sat = 0; a_if.load = 1; a_if.din = 4'd13;
        tick();
        check("a_load_clamp", 32'(a_if.q), 9);
        a_if.din = 4'd3; a_if.en = 1; a_if.up = 1;
        tick();
        check("a_load_beats_en", 32'(a_if.q), 3);
        check("a_load_keeps_ovf", 32'(a_if.ovf), 1);
        a_if.load = 0; a_if.en = 0;
        tick();
        check("a_hold_q", 32'(a_if.q), 3);
        check("a_hold_ovf", 32'(a_if.ovf), 1);

        a_if.load = 1; a_if.din = 4'd7;
        tick();
        check("a_load7", 32'(a_if.q), 7);
        a_if.en = 1; a_if.up = 1; a_if.clr = 1; a_if.din = 4'd5;
        tick();
        check("a_clr_over_load_q", 32'(a_if.q), 0);
        check("a_clr_over_load_ovf", 32'(a_if.ovf), 0);
        a_if.clr = 0; a_if.en = 0; a_if.din = 4'd7;
        tick();
        check("a_reload7", 32'(a_if.q), 7);
        rst_a = 1; a_if.clr = 1; a_if.en = 1;
        tick();
        check("a_rst_over_all", 32'(a_if.q), 0);
        rst_a = 0; a_if.clr = 0; a_if.en = 0;

        // Reset arriving on the edge that would otherwise wrap
        a_if.din = 4'd9;
        tick();
        rst_a = 1; a_if.load = 0; a_if.en = 1; a_if.up = 1;
        tick();
        check("a_rst_mid_q", 32'(a_if.q), 0);
        check("a_rst_mid_wrap", 32'(a_if.wrap), 0);
        rst_a = 0; a_if.en = 0;
        tick();
        check("a_post_rst_wrap", 32'(a_if.wrap), 0);

        a_if.load = 1; a_if.din = 4'd9;
        tick();
        a_if.load = 0; a_if.en = 1; a_if.up = 1; a_if.sat = 1;
        tick();
        check("a_sat_up_q", 32'(a_if.q), 9);
        check("a_sat_up_wrap", 32'(a_if.wrap), 0);
        check("a_sat_up_ovf", 32'(a_if.ovf), 1);
        a_if.sat = 0;
        tick();
        check("a_sat_off_wraps_q", 32'(a_if.q), 0);
        check("a_sat_off_wraps_wrap", 32'(a_if.wrap), 1);
        a_if.en = 0;

        // 8-bit full-range wrap downward
        rst_b = 0; b_if.en = 1; b_if.up = 0; b_if.sat = 0;
        tick();
        check("b_dn_wrap_q", 32'(b_if.q), 255);
        check("b_dn_wrap_wrap", 32'(b_if.wrap), 1);
        check("b_dn_wrap_ovf", 32'(b_if.ovf), 1);
        b_if.en = 0;
        tick();
        check("b_wrap_one_cycle", 32'(b_if.wrap), 0);
        check("b_hold_q", 32'(b_if.q), 255);
        b_if.en = 1; b_if.up = 1;
        tick();
        check("b_up_wrap_q", 32'(b_if.q), 0);
        check("b_up_wrap_wrap", 32'(b_if.wrap), 1);
        b_if.en = 0;

        // MAX=1 toggling, then reverse direction at q=1
        rst_c = 0; c_if.en = 1; c_if.up = 1; c_if.sat = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("c_q[%0d]", i), 32'(c_if.q), 32'(exp_c_q[i]));
            check($sformatf("c_wrap[%0d]", i), 32'(c_if.wrap), 32'(exp_c_w[i]));
        end
        tick();
        check("c_q_before_rev", 32'(c_if.q), 1);
        c_if.up = 0;
        tick();
        check("c_rev_q", 32'(c_if.q), 0);
        check("c_rev_wrap", 32'(c_if.wrap), 0);
        check("c_ovf_sticky", 32'(c_if.ovf), 1);
        c_if.en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
